// File: rtl/floo_test_pkg.sv
// Shared types for the out-of-order AXI read responder: slot record, field widths, LFSR helpers.
// Slot fields are sized by the Rsp*Width localparams; widen them here when the top is built wider.
package floo_test_pkg;

  localparam int unsigned RspIdWidth   = 4;
  localparam int unsigned RspAddrWidth = 32;
  localparam int unsigned RspLenWidth  = 8;
  localparam int unsigned RspPredWidth = 8;

  // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10.
  localparam logic [15:0] RspLfsrTaps = 16'hB400;

  typedef struct packed {
    logic                    valid;
    logic [RspIdWidth-1:0]   id;
    logic [RspAddrWidth-1:0] addr;
    logic [RspLenWidth-1:0]  len;
    logic [RspLenWidth-1:0]  beat;
    logic [RspPredWidth-1:0] pred;
  } rsp_slot_t;

  function automatic logic [15:0] rsp_lfsr_next(input logic [15:0] lfsr);
    return {lfsr[14:0], ^(lfsr & RspLfsrTaps)};
  endfunction

endpackage

// File: rtl/floo_rsp_slot_picker.sv
// Combinational rotated-priority picker: first set bit of eligible_i at or after start_i, wrapping.
// Also used with start_i=0 as a plain lowest-index finder.
module floo_rsp_slot_picker #(
  parameter int unsigned NumSlots = 8,
  parameter int unsigned IdxW     = $clog2(NumSlots)
) (
  input  logic [NumSlots-1:0] eligible_i,
  input  logic [IdxW-1:0]     start_i,
  output logic [IdxW-1:0]     idx_o,
  output logic                found_o
);

  int unsigned      pos;
  logic [IdxW-1:0]  pos_idx;

  // NOTE: every output and temporary gets a default before the loop so no path leaves a latch.
  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned i = 0; i < NumSlots; i++) begin
      pos     = (32'(start_i) + i) % NumSlots;
      pos_idx = IdxW'(pos);
      if (!found_o && eligible_i[pos_idx]) begin
        found_o = 1'b1;
        idx_o   = pos_idx;
      end
    end
  end

endmodule

// File: rtl/floo_axi_ooo_read_responder.sv
// AXI read responder answering bursts out of order (same-ID bursts stay in issue order).
// Optional macro FLOO_OOO_RSP_RANDOM_STALL_EN inserts LFSR-driven bubbles between launched beats.
module floo_axi_ooo_read_responder
  import floo_test_pkg::*;
#(
  parameter int unsigned NumSlots  = 8,
  parameter int unsigned IdWidth   = RspIdWidth,
  parameter int unsigned AddrWidth = RspAddrWidth,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned LenWidth  = RspLenWidth,
  parameter logic [15:0] LfsrSeed  = 16'hACE1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ar_valid_i,
  output logic                 ar_ready_o,
  input  logic [IdWidth-1:0]   ar_id_i,
  input  logic [AddrWidth-1:0] ar_addr_i,
  input  logic [LenWidth-1:0]  ar_len_i,
  output logic                 r_valid_o,
  input  logic                 r_ready_i,
  output logic [IdWidth-1:0]   r_id_o,
  output logic [DataWidth-1:0] r_data_o,
  output logic [1:0]           r_resp_o,
  output logic                 r_last_o
);

  localparam int unsigned IdxW     = $clog2(NumSlots);
  localparam int unsigned ByteOffW = $clog2(DataWidth / 8);

  rsp_slot_t slots_q   [NumSlots];
  rsp_slot_t slots_upd [NumSlots];
  rsp_slot_t slots_d   [NumSlots];

  logic [15:0]           lfsr_q, lfsr_d;
  logic                  ar_ready_q, ar_ready_d;
  logic                  r_valid_q, r_valid_d;
  logic [IdWidth-1:0]    r_id_q, r_id_d;
  logic [DataWidth-1:0]  r_data_q, r_data_d;
  logic                  r_last_q, r_last_d;
  logic [IdxW-1:0]       r_slot_q, r_slot_d;

  logic [NumSlots-1:0]   eligible, free;
  logic [IdxW-1:0]       pick_idx, free_idx;
  logic                  pick_found, free_found;
  logic                  r_hs, ar_hs, launch;
  logic [RspPredWidth-1:0] same_cnt;
  logic [RspAddrWidth-1:0] beat_addr;

  // Handshake effects on the registered slots: advance the presented beat or retire its burst.
  always_comb begin
    r_hs = r_valid_q && r_ready_i;
    for (int i = 0; i < NumSlots; i++) slots_upd[i] = slots_q[i];
    if (r_hs) begin
      if (r_last_q) begin
        slots_upd[r_slot_q].valid = 1'b0;
        for (int i = 0; i < NumSlots; i++) begin
          if (slots_q[i].valid && (IdxW'(i) != r_slot_q) &&
              (slots_q[i].id == slots_q[r_slot_q].id) && (slots_q[i].pred != '0)) begin
            slots_upd[i].pred = slots_q[i].pred - RspPredWidth'(1);
          end
        end
      end else begin
        slots_upd[r_slot_q].beat = slots_q[r_slot_q].beat + RspLenWidth'(1);
      end
    end
    for (int i = 0; i < NumSlots; i++) begin
      eligible[i] = slots_upd[i].valid && (slots_upd[i].pred == '0);
      free[i]     = !slots_q[i].valid;
    end
  end

  floo_rsp_slot_picker #(.NumSlots(NumSlots), .IdxW(IdxW)) i_beat_picker (
    .eligible_i (eligible),
    .start_i    (lfsr_q[IdxW-1:0]),
    .idx_o      (pick_idx),
    .found_o    (pick_found)
  );

  floo_rsp_slot_picker #(.NumSlots(NumSlots), .IdxW(IdxW)) i_free_picker (
    .eligible_i (free),
    .start_i    ('0),
    .idx_o      (free_idx),
    .found_o    (free_found)
  );

  // Allocation sees the post-retire view, so a same-cycle retire is not counted as a predecessor.
  always_comb begin
    ar_hs    = ar_valid_i && ar_ready_q;
    same_cnt = '0;
    for (int i = 0; i < NumSlots; i++) begin
      slots_d[i] = slots_upd[i];
      if (slots_upd[i].valid && (slots_upd[i].id == RspIdWidth'(ar_id_i))) begin
        same_cnt = same_cnt + RspPredWidth'(1);
      end
    end
    if (ar_hs && free_found) begin
      slots_d[free_idx].valid = 1'b1;
      slots_d[free_idx].id    = RspIdWidth'(ar_id_i);
      slots_d[free_idx].addr  = RspAddrWidth'(ar_addr_i);
      slots_d[free_idx].len   = RspLenWidth'(ar_len_i);
      slots_d[free_idx].beat  = '0;
      slots_d[free_idx].pred  = same_cnt;
    end
    ar_ready_d = 1'b0;
    for (int i = 0; i < NumSlots; i++) begin
      if (!slots_d[i].valid) ar_ready_d = 1'b1;
    end
    lfsr_d = rsp_lfsr_next(lfsr_q);
  end

  always_comb begin
`ifdef FLOO_OOO_RSP_RANDOM_STALL_EN
    launch = pick_found && (lfsr_q[15:14] != 2'b00);
`else
    launch = pick_found;
`endif
    beat_addr = slots_upd[pick_idx].addr +
                (RspAddrWidth'(slots_upd[pick_idx].beat) << ByteOffW);
    r_valid_d = r_valid_q;
    r_id_d    = r_id_q;
    r_data_d  = r_data_q;
    r_last_d  = r_last_q;
    r_slot_d  = r_slot_q;
    // A held beat freezes the whole R register until it is accepted.
    if (!r_valid_q || r_ready_i) begin
      r_valid_d = launch;
      if (launch) begin
        r_id_d   = IdWidth'(slots_upd[pick_idx].id);
        r_data_d = DataWidth'(beat_addr);
        r_last_d = (slots_upd[pick_idx].beat == slots_upd[pick_idx].len);
        r_slot_d = pick_idx;
      end
    end
  end

  // NOTE: the slot array is reset as a whole because in-flight bursts must vanish on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumSlots; i++) slots_q[i] <= '0;
      lfsr_q     <= LfsrSeed;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_id_q     <= '0;
      r_data_q   <= '0;
      r_last_q   <= 1'b0;
      r_slot_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      for (int i = 0; i < NumSlots; i++) slots_q[i] <= slots_d[i];
      lfsr_q     <= lfsr_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_id_q     <= r_id_d;
      r_data_q   <= r_data_d;
      r_last_q   <= r_last_d;
      r_slot_q   <= r_slot_d;
    end
  end

  assign ar_ready_o = ar_ready_q;
  assign r_valid_o  = r_valid_q;
  assign r_id_o     = r_id_q;
  assign r_data_o   = r_data_q;
  assign r_resp_o   = 2'b00;
  assign r_last_o   = r_last_q;

endmodule

// File: tb/tb_floo_axi_ooo_read_responder.sv
// Directed bench for floo_axi_ooo_read_responder: bursts, ordering, backpressure, reset, wrap.
module tb_floo_axi_ooo_read_responder;

  localparam int IdW = 4;
  localparam int AW  = 32;
  localparam int DW  = 64;
  localparam int LW  = 8;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           ar_valid_i;
  logic           ar_ready_o;
  logic [IdW-1:0] ar_id_i;
  logic [AW-1:0]  ar_addr_i;
  logic [LW-1:0]  ar_len_i;
  logic           r_valid_o;
  logic           r_ready_i;
  logic [IdW-1:0] r_id_o;
  logic [DW-1:0]  r_data_o;
  logic [1:0]     r_resp_o;
  logic           r_last_o;

  int checks = 0;
  int errors = 0;

  logic [IdW-1:0] mon_id[$];
  logic [DW-1:0]  mon_data[$];
  logic           mon_last[$];
  logic [1:0]     mon_resp[$];

  floo_axi_ooo_read_responder dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ar_valid_i (ar_valid_i),
    .ar_ready_o (ar_ready_o),
    .ar_id_i    (ar_id_i),
    .ar_addr_i  (ar_addr_i),
    .ar_len_i   (ar_len_i),
    .r_valid_o  (r_valid_o),
    .r_ready_i  (r_ready_i),
    .r_id_o     (r_id_o),
    .r_data_o   (r_data_o),
    .r_resp_o   (r_resp_o),
    .r_last_o   (r_last_o)
  );

  always #5 clk_i = ~clk_i;

  // Log every R beat that will handshake at the next rising edge.
  always @(negedge clk_i) begin
    if (!rst_i && r_valid_o && r_ready_i) begin
      mon_id.push_back(r_id_o);
      mon_data.push_back(r_data_o);
      mon_last.push_back(r_last_o);
      mon_resp.push_back(r_resp_o);
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_ar(input logic [IdW-1:0] id, input logic [AW-1:0] addr,
                         input logic [LW-1:0] len);
    bit done = 0;
    ar_valid_i = 1'b1;
    ar_id_i    = id;
    ar_addr_i  = addr;
    ar_len_i   = len;
    for (int c = 0; c < 50 && !done; c++) begin
      if (ar_ready_o) done = 1;
      step();
    end
    ar_valid_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL ar_handshake id=%0d: ar_ready_o=0 for 50 cycles, required 1", id);
    end
  endtask

  task automatic wait_beats(input int total, input int max_cycles, input string tag);
    int c = 0;
    while (mon_data.size() < total && c < max_cycles) begin
      step();
      c++;
    end
    checks++;
    if (mon_data.size() < total) begin
      errors++;
      $display("FAIL %s beat_count: got %0d beats, required %0d", tag, mon_data.size(), total);
    end
  endtask

  task automatic wait_rvalid(input int max_cycles, input string tag);
    int c = 0;
    while (!r_valid_o && c < max_cycles) begin
      step();
      c++;
    end
    checks++;
    if (!r_valid_o) begin
      errors++;
      $display("FAIL %s r_valid_timeout: r_valid_o=0, required 1", tag);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    ar_valid_i = 1'b0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0; r_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    checks++;
    if ({r_valid_o, ar_ready_o, r_last_o} !== 3'b000 || r_id_o !== '0 || r_data_o !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b last=%b id=%0h data=%0h, required all 0",
               r_valid_o, ar_ready_o, r_last_o, r_id_o, r_data_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    checks++;
    if (ar_ready_o !== 1'b1 || r_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ar_ready=%b r_valid=%b, required 1/0", ar_ready_o, r_valid_o);
    end
  endtask

  task automatic test_single_burst();
    int base = mon_data.size();
    logic [DW-1:0] exp_d;
    r_ready_i = 1'b1;
    send_ar(4'd1, 32'h1000, 8'd3);
    wait_beats(base + 4, 60, "single");
    for (int k = 0; k < 4; k++) begin
      exp_d = 64'h1000 + 64'(8 * k);
      checks++;
      if (base + k >= mon_data.size()) begin
        errors++;
        $display("FAIL single_beat%0d: missing, required data %0h", k, exp_d);
      end else if (mon_data[base+k] !== exp_d || mon_id[base+k] !== 4'd1 ||
                   mon_last[base+k] !== (k == 3) || mon_resp[base+k] !== 2'b00) begin
        errors++;
        $display("FAIL single_beat%0d: data=%0h id=%0h last=%b resp=%b, required %0h 1 %b 00",
                 k, mon_data[base+k], mon_id[base+k], mon_last[base+k], mon_resp[base+k],
                 exp_d, (k == 3));
      end
    end
  endtask

  task automatic test_same_id_order();
    int base = mon_data.size();
    logic [DW-1:0] exp_d [3];
    logic          exp_l [3];
    exp_d[0] = 64'h2000; exp_d[1] = 64'h2008; exp_d[2] = 64'h3000;
    exp_l[0] = 1'b0;     exp_l[1] = 1'b1;     exp_l[2] = 1'b1;
    r_ready_i = 1'b0;
    send_ar(4'd2, 32'h2000, 8'd1);
    send_ar(4'd2, 32'h3000, 8'd0);
    r_ready_i = 1'b1;
    wait_beats(base + 3, 60, "same_id");
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (base + k >= mon_data.size()) begin
        errors++;
        $display("FAIL same_id_beat%0d: missing, required data %0h", k, exp_d[k]);
      end else if (mon_data[base+k] !== exp_d[k] || mon_last[base+k] !== exp_l[k] ||
                   mon_id[base+k] !== 4'd2) begin
        errors++;
        $display("FAIL same_id_beat%0d: data=%0h last=%b id=%0h, required %0h %b 2",
                 k, mon_data[base+k], mon_last[base+k], mon_id[base+k], exp_d[k], exp_l[k]);
      end
    end
  endtask

  task automatic test_backpressure();
    int base = mon_data.size();
    logic [DW-1:0]  s_data;
    logic [IdW-1:0] s_id;
    logic           s_last;
    r_ready_i = 1'b0;
    send_ar(4'd3, 32'h4000, 8'd3);
    wait_rvalid(20, "stall_first");
    r_ready_i = 1'b1;
    step();
    r_ready_i = 1'b0;
    wait_rvalid(20, "stall_second");
    s_data = r_data_o; s_id = r_id_o; s_last = r_last_o;
    checks++;
    if (s_data !== 64'h4008 || s_id !== 4'd3 || s_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_held_beat: data=%0h id=%0h last=%b, required 4008 3 0",
               s_data, s_id, s_last);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      checks++;
      if (r_valid_o !== 1'b1 || r_data_o !== s_data || r_id_o !== s_id ||
          r_last_o !== s_last || r_resp_o !== 2'b00) begin
        errors++;
        $display("FAIL stall_hold_cycle%0d: valid=%b data=%0h id=%0h last=%b, required 1 %0h %0h %b",
                 c, r_valid_o, r_data_o, r_id_o, r_last_o, s_data, s_id, s_last);
      end
    end
    r_ready_i = 1'b1;
    wait_beats(base + 4, 60, "stall");
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (base + k >= mon_data.size() || mon_data[base+k] !== 64'h4000 + 64'(8 * k)) begin
        errors++;
        $display("FAIL stall_beat%0d: data wrong or missing, required %0h", k, 64'h4000 + 64'(8 * k));
      end
    end
  endtask

  task automatic test_addr_wrap();
    int base = mon_data.size();
    r_ready_i = 1'b1;
    send_ar(4'd5, 32'hFFFF_FFF8, 8'd1);
    wait_beats(base + 2, 40, "wrap");
    checks++;
    if (mon_data.size() < base + 2 || mon_data[base] !== 64'h0000_0000_FFFF_FFF8 ||
        mon_data[base+1] !== 64'h0 || mon_last[base] !== 1'b0 || mon_last[base+1] !== 1'b1) begin
      errors++;
      $display("FAIL addr_wrap: beats wrong or missing, required ffff_fff8/0 with last 0/1");
    end
  endtask

  task automatic test_full_interleave();
    int base = mon_data.size();
    int nxt [8];
    int lasts = 0, bad = 0, changes = 0;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 8; i++) nxt[i] = 0;
    r_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) send_ar(IdW'(i), 32'h1_0000 + 32'(i * 'h1000), 8'd7);
    checks++;
    if (ar_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL full_ar_ready: ar_ready_o=%b, required 0", ar_ready_o);
    end
    r_ready_i = 1'b1;
    wait_beats(base + 64, 400, "full");
    for (int k = base; k < mon_data.size(); k++) begin
      int id = int'(mon_id[k]);
      if (k > base && mon_id[k] !== mon_id[k-1]) changes++;
      if (mon_last[k]) lasts++;
      if (id > 7 || nxt[id] > 7) begin
        bad++;
      end else begin
        exp_d = 64'h1_0000 + 64'(id * 'h1000) + 64'(8 * nxt[id]);
        if (mon_data[k] !== exp_d || mon_last[k] !== (nxt[id] == 7)) bad++;
        nxt[id]++;
      end
    end
    checks++;
    if (mon_data.size() - base != 64) begin
      errors++;
      $display("FAIL full_total_beats: got %0d, required 64", mon_data.size() - base);
    end
    checks++;
    if (lasts != 8) begin
      errors++;
      $display("FAIL full_last_pulses: got %0d, required 8", lasts);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL full_per_id_order: %0d beats out of sequence, required 0", bad);
    end
    checks++;
    if (changes < 8) begin
      errors++;
      $display("FAIL full_interleave: %0d id switches, required at least 8", changes);
    end
    checks++;
    if (ar_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL full_drained_ready: ar_ready_o=%b, required 1", ar_ready_o);
    end
  endtask

  task automatic test_reset_in_flight();
    int base;
    r_ready_i = 1'b0;
    send_ar(4'd4, 32'h5000, 8'd3);
    send_ar(4'd5, 32'h6000, 8'd3);
    send_ar(4'd6, 32'h7000, 8'd3);
    wait_rvalid(20, "rst_flight");
    base = mon_data.size();
    rst_i = 1'b1;
    #1;
    checks++;
    if (r_valid_o !== 1'b0 || ar_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_flight_assert: r_valid=%b ar_ready=%b, required 0/0", r_valid_o, ar_ready_o);
    end
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    step();
    checks++;
    if (ar_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL rst_flight_release: ar_ready=%b, required 1", ar_ready_o);
    end
    r_ready_i = 1'b1;
    repeat (10) step();
    checks++;
    if (mon_data.size() != base || r_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rst_flight_stale: %0d beats after reset, r_valid=%b, required 0/0",
               mon_data.size() - base, r_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_same_id_order();
    test_backpressure();
    test_addr_wrap();
    test_full_interleave();
    test_reset_in_flight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
